// File: rtl/or1200_immu_tlb_nway_if.sv
// Lookup and SPR-window signals of the N-way instruction TLB.
//   lkp_*  : fetch lookup request (virtual address in) and registered result out
//   spr_*  : group-2 SPR access window (MR/TR entries, set invalidate, flush-all)
// master = fetch unit / SPR bus side, slave = TLB.
interface or1200_immu_tlb_nway_if #(
    parameter int AW    = 32,
    parameter int WAY_W = 1
);
    logic             lkp_req_i;
    logic [AW-1:0]    lkp_adr_i;
    logic             lkp_vld_o;
    logic             lkp_hit_o;
    logic             lkp_miss_o;
    logic             lkp_fault_o;
    logic [AW-1:0]    lkp_adr_o;
    logic             lkp_ci_o;
    logic [WAY_W-1:0] lkp_victim_o;
    logic             spr_cs;
    logic             spr_write;
    logic [10:0]      spr_addr;
    logic [31:0]      spr_dat_i;
    logic [31:0]      spr_dat_o;

    modport master (
        output lkp_req_i, lkp_adr_i, spr_cs, spr_write, spr_addr, spr_dat_i,
        input  lkp_vld_o, lkp_hit_o, lkp_miss_o, lkp_fault_o, lkp_adr_o,
               lkp_ci_o, lkp_victim_o, spr_dat_o
    );

    modport slave (
        input  lkp_req_i, lkp_adr_i, spr_cs, spr_write, spr_addr, spr_dat_i,
        output lkp_vld_o, lkp_hit_o, lkp_miss_o, lkp_fault_o, lkp_adr_o,
               lkp_ci_o, lkp_victim_o, spr_dat_o
    );
endinterface

// File: rtl/or1200_immu_tlb_nway.sv
// N-way set-associative instruction TLB with one-cycle registered lookup,
// supervisor/user execute check, per-set round-robin refill hint, single-set
// invalidate and a flush-all walker that clears one set per cycle.
// Ports:
//   clk, rst (async, active low), immu_en (translation enable), supv
//   (supervisor mode), busy_o (flush-all in progress), bus (lookup + SPR
//   window, slave side).
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | normal operation, lookups accepted
// ST_WALK | flush-all: clearing set cnt_q each cycle, lookups blocked
module or1200_immu_tlb_nway #(
    parameter int AW        = 32,
    parameter int NUM_SETS  = 64,
    parameter int NUM_WAYS  = 2,
    parameter int PAGE_BITS = 13
) (
    input  logic clk,
    input  logic rst,
    input  logic immu_en,
    input  logic supv,
    output logic busy_o,
    or1200_immu_tlb_nway_if.slave bus
);
    localparam int SET_W = $clog2(NUM_SETS);
    localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam int TAG_W = AW - PAGE_BITS - SET_W;
    localparam int PPN_W = AW - PAGE_BITS;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WALK = 1'b1;

    logic [TAG_W-1:0] mr_tag_q [NUM_WAYS][NUM_SETS], mr_tag_d [NUM_WAYS][NUM_SETS];
    logic             mr_v_q   [NUM_WAYS][NUM_SETS], mr_v_d   [NUM_WAYS][NUM_SETS];
    logic [PPN_W-1:0] tr_ppn_q [NUM_WAYS][NUM_SETS], tr_ppn_d [NUM_WAYS][NUM_SETS];
    logic             tr_ci_q  [NUM_WAYS][NUM_SETS], tr_ci_d  [NUM_WAYS][NUM_SETS];
    logic             tr_sxe_q [NUM_WAYS][NUM_SETS], tr_sxe_d [NUM_WAYS][NUM_SETS];
    logic             tr_uxe_q [NUM_WAYS][NUM_SETS], tr_uxe_d [NUM_WAYS][NUM_SETS];
    logic [WAY_W-1:0] vict_q   [NUM_SETS],           vict_d   [NUM_SETS];

    logic [0:0]       state_q, state_d;
    logic [SET_W-1:0] cnt_q, cnt_d;

    logic             vld_q, vld_d, hit_q, hit_d, miss_q, miss_d, fault_q, fault_d, ci_q, ci_d;
    logic [AW-1:0]    adr_q, adr_d;
    logic [WAY_W-1:0] victim_q, victim_d;

    // SPR decode: region 2+w of the offset selects way w, bit 7 picks TR over MR
    logic [AW-1:0]    wdat;
    logic [2:0]       rgn, wsel3;
    logic             spr_ent_ok, spr_is_tr, flush_wr, spr_wr;
    logic [WAY_W-1:0] spr_w;
    logic [SET_W-1:0] spr_s, inv_set;
    logic [AW-1:0]    rd;
    logic             unused_wdat;

    assign wdat       = AW'(bus.spr_dat_i);
    assign rgn        = bus.spr_addr[10:8];
    assign wsel3      = rgn - 3'd2;
    assign spr_is_tr  = bus.spr_addr[7];
    assign spr_ent_ok = (rgn >= 3'd2) && (int'(wsel3) < NUM_WAYS)
                        && (int'(bus.spr_addr[6:0]) < NUM_SETS);
    assign spr_w      = wsel3[WAY_W-1:0];
    assign spr_s      = bus.spr_addr[SET_W-1:0];
    assign inv_set    = wdat[PAGE_BITS+SET_W-1:PAGE_BITS];
    assign spr_wr     = bus.spr_cs && bus.spr_write;
    assign flush_wr   = spr_wr && (bus.spr_addr == 11'h003);
    assign unused_wdat = ^{wdat[PAGE_BITS-1:8], wdat[5:2]};

    always_comb begin
        rd = '0;
        if (bus.spr_cs && !bus.spr_write && spr_ent_ok) begin
            if (spr_is_tr) begin
                rd[AW-1:PAGE_BITS] = tr_ppn_q[spr_w][spr_s];
                rd[1]              = tr_ci_q[spr_w][spr_s];
                rd[6]              = tr_sxe_q[spr_w][spr_s];
                rd[7]              = tr_uxe_q[spr_w][spr_s];
            end else begin
                rd[AW-1:PAGE_BITS+SET_W] = mr_tag_q[spr_w][spr_s];
                rd[0]                    = mr_v_q[spr_w][spr_s];
            end
        end
    end
    assign bus.spr_dat_o = 32'(rd);

    // Lookup match; scanning downward leaves the lowest matching way selected
    logic [TAG_W-1:0] lk_tag;
    logic [SET_W-1:0] lk_set;
    logic             found, perm;
    logic [WAY_W-1:0] sel;

    assign lk_tag = bus.lkp_adr_i[AW-1:PAGE_BITS+SET_W];
    assign lk_set = bus.lkp_adr_i[PAGE_BITS+SET_W-1:PAGE_BITS];

    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (mr_v_q[w][lk_set] && (mr_tag_q[w][lk_set] == lk_tag)) begin
                found = 1'b1;
                sel   = WAY_W'(w);
            end
        end
        perm = supv ? tr_sxe_q[sel][lk_set] : tr_uxe_q[sel][lk_set];
    end

    // Lookup reads only _q arrays, so a same-cycle SPR write is not seen by it
    always_comb begin
        mr_tag_d = mr_tag_q;
        mr_v_d   = mr_v_q;
        tr_ppn_d = tr_ppn_q;
        tr_ci_d  = tr_ci_q;
        tr_sxe_d = tr_sxe_q;
        tr_uxe_d = tr_uxe_q;
        vict_d   = vict_q;
        state_d  = state_q;
        cnt_d    = cnt_q;
        vld_d    = 1'b0;
        hit_d    = 1'b0;
        miss_d   = 1'b0;
        fault_d  = 1'b0;
        ci_d     = 1'b0;
        adr_d    = '0;
        victim_d = '0;

        if (bus.lkp_req_i && (state_q == ST_IDLE)) begin
            vld_d = 1'b1;
            if (!immu_en) begin
                hit_d = 1'b1;
                adr_d = bus.lkp_adr_i;
            end else if (found && perm) begin
                hit_d = 1'b1;
                adr_d = {tr_ppn_q[sel][lk_set], bus.lkp_adr_i[PAGE_BITS-1:0]};
                ci_d  = tr_ci_q[sel][lk_set];
            end else if (found) begin
                fault_d = 1'b1;
            end else begin
                miss_d         = 1'b1;
                victim_d       = vict_q[lk_set];
                vict_d[lk_set] = (vict_q[lk_set] == WAY_W'(NUM_WAYS - 1)) ? '0
                                 : vict_q[lk_set] + 1'b1;
            end
        end

        if (spr_wr) begin
            if (spr_ent_ok) begin
                if (spr_is_tr) begin
                    tr_ppn_d[spr_w][spr_s] = wdat[AW-1:PAGE_BITS];
                    tr_ci_d[spr_w][spr_s]  = wdat[1];
                    tr_sxe_d[spr_w][spr_s] = wdat[6];
                    tr_uxe_d[spr_w][spr_s] = wdat[7];
                end else begin
                    mr_tag_d[spr_w][spr_s] = wdat[AW-1:PAGE_BITS+SET_W];
                    mr_v_d[spr_w][spr_s]   = wdat[0];
                end
            end else if (bus.spr_addr == 11'h002) begin
                for (int w = 0; w < NUM_WAYS; w++) mr_v_d[w][inv_set] = 1'b0;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (flush_wr) begin
                    state_d = ST_WALK;
                    cnt_d   = '0;
                end
            end
            ST_WALK: begin
                // whole MR word is cleared so a flushed entry reads back as 0
                for (int w = 0; w < NUM_WAYS; w++) begin
                    mr_v_d[w][cnt_q]   = 1'b0;
                    mr_tag_d[w][cnt_q] = '0;
                end
                vict_d[cnt_q] = '0;
                if (flush_wr)                              cnt_d = '0;
                else if (cnt_q == SET_W'(NUM_SETS - 1))    state_d = ST_IDLE;
                else                                       cnt_d = cnt_q + 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mr_tag_q <= '{default: '0};
            mr_v_q   <= '{default: '0};
            tr_ppn_q <= '{default: '0};
            tr_ci_q  <= '{default: '0};
            tr_sxe_q <= '{default: '0};
            tr_uxe_q <= '{default: '0};
            vict_q   <= '{default: '0};
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            vld_q    <= 1'b0;
            hit_q    <= 1'b0;
            miss_q   <= 1'b0;
            fault_q  <= 1'b0;
            ci_q     <= 1'b0;
            adr_q    <= '0;
            victim_q <= '0;
        end else begin
            mr_tag_q <= mr_tag_d;
            mr_v_q   <= mr_v_d;
            tr_ppn_q <= tr_ppn_d;
            tr_ci_q  <= tr_ci_d;
            tr_sxe_q <= tr_sxe_d;
            tr_uxe_q <= tr_uxe_d;
            vict_q   <= vict_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            vld_q    <= vld_d;
            hit_q    <= hit_d;
            miss_q   <= miss_d;
            fault_q  <= fault_d;
            ci_q     <= ci_d;
            adr_q    <= adr_d;
            victim_q <= victim_d;
        end
    end

    assign busy_o           = (state_q == ST_WALK);
    assign bus.lkp_vld_o    = vld_q;
    assign bus.lkp_hit_o    = hit_q;
    assign bus.lkp_miss_o   = miss_q;
    assign bus.lkp_fault_o  = fault_q;
    assign bus.lkp_adr_o    = adr_q;
    assign bus.lkp_ci_o     = ci_q;
    assign bus.lkp_victim_o = victim_q;
endmodule

// File: doc/or1200_immu_tlb_nway.md
Name: or1200_immu_tlb_nway

Overview:
Parametrised N-way set-associative instruction TLB. It is the translation core of the next-generation IMMU and replaces the fixed single-way ITLB. It translates fetch virtual addresses to physical addresses with one-cycle registered latency and checks supervisor/user execute permission. Match (MR) and translate (TR) entries are accessed through the SPR group-2 window. It adds three features: a per-set round-robin victim hint on miss, a single-set invalidate, and a multi-cycle flush-all sequencer.

Parameters:
AW, 32, virtual/physical address width
NUM_SETS, 64, sets per way; power of 2, 2..128
NUM_WAYS, 2, ways; 1..4
PAGE_BITS, 13, page offset bits (8 KB pages)
Derived: SET_W = log2(NUM_SETS); WAY_W = max(1, log2(NUM_WAYS)); TAG = adr[AW-1:PAGE_BITS+SET_W]; SET = adr[PAGE_BITS+SET_W-1:PAGE_BITS]

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
immu_en  in  1  translation enable
supv  in  1  supervisor mode
lkp_req_i  in  1  lookup request
lkp_adr_i  in  AW  virtual fetch address
lkp_vld_o  out  1  lookup result valid (one cycle after an accepted request)
lkp_hit_o  out  1  translation hit, permission granted
lkp_miss_o  out  1  no valid matching entry
lkp_fault_o  out  1  match found, execute not permitted
lkp_adr_o  out  AW  physical address
lkp_ci_o  out  1  cache-inhibit from TR
lkp_victim_o  out  WAY_W  suggested refill way on miss
busy_o  out  1  flush-all in progress
spr_cs  in  1  SPR select (group 2)
spr_write  in  1  1 = write, 0 = read
spr_addr  in  11  offset within group 2
spr_dat_i  in  32  SPR write data
spr_dat_o  out  32  SPR read data (combinational)

Behaviour:
- Reset (rst=0, asynchronous): all MR/TR storage = 0, victim pointers = 0, flush FSM = IDLE. Outputs: lkp_vld_o, hit, miss, fault, ci, busy_o = 0; lkp_adr_o = 0; lkp_victim_o = 0.
- MR format: bit0 = V; bits [AW-1:PAGE_BITS+SET_W] = VPN tag; other bits read 0.
- TR format: [AW-1:PAGE_BITS] = PPN; bit1 = CI; bit6 = SXE; bit7 = UXE; other bits read 0.
- SPR map: offset 0x200 + 0x100*w + s = MR(way w, set s). Offset 0x280 + 0x100*w + s = TR(way w, set s). Offset 0x002 write = invalidate set SET(spr_dat_i) in all ways. Offset 0x003 write = flush-all.
- SPR writes take effect at the clock edge. Reads of unmapped offsets, or of a way/set outside the parameters, return 0. Writes to them are ignored.
- Lookup is accepted when lkp_req_i=1 and busy_o=0. Results are registered and appear next cycle with lkp_vld_o=1 for exactly one cycle. Back-to-back requests produce one result per cycle.
- immu_en=0: hit=1, lkp_adr_o = lkp_adr_i, ci=0.
- immu_en=1: a way matches when V=1 and the tag is equal. Lowest-index matching way wins.
  - Match and (supv ? SXE : UXE) set: hit=1; lkp_adr_o = {PPN, adr[PAGE_BITS-1:0]}; ci = CI.
  - Match, permission clear: fault=1, hit=0, lkp_adr_o = 0.
  - No match: miss=1; lkp_victim_o = victim pointer of that set; pointer then increments mod NUM_WAYS.
- Exactly one of hit/miss/fault is set when vld=1. All are 0 when vld=0.
- SPR write and lookup to the same entry in the same cycle: the lookup uses the pre-write contents.
- Flush FSM:
  - IDLE: on a flush-all write, go to WALK with counter = 0 and busy_o = 1.
  - WALK: each cycle clear V in all ways of set `counter` and zero its victim pointer. At counter = NUM_SETS-1, return to IDLE; busy_o drops the following cycle. Flush takes NUM_SETS cycles.
  - While busy: lookups are not accepted (no vld). SPR writes other than flush are applied. A further flush write restarts the counter at 0.
- Reset asserted mid-flush aborts immediately to IDLE.

Test Plan:
- Reset: pulse rst=0 for 3 ns -> all lookup outputs 0, busy_o=0; read 0x205 -> 0x00000000.
- Hit: write 0x205=0x00080001 and 0x285=0x12346042; supv=1, lookup 0x0008A124 -> next cycle vld=1, hit=1, adr_o=0x12346124, ci=1.
- Fault: same entries, supv=0 (UXE=0), lookup 0x0008A124 -> vld=1, fault=1, hit=0, miss=0.
- Victim rotation: NUM_WAYS=2, lookup 0x0010A000 three times -> miss=1 each time, victim = 0, 1, 0.
- Flush: write 0x003 -> busy_o=1 for 64 cycles, a lookup during busy gives no vld. Afterwards 0x0008A124 -> miss=1 and 0x205 reads 0. Assert rst mid-flush -> busy_o=0 immediately.
- Bypass: immu_en=0, lookup 0xDEADB000 -> hit=1, adr_o=0xDEADB000, ci=0.
